// File: rtl/mac_8_seq_ctrl.sv
// mac_8_seq_ctrl: sequencer for one multiply-accumulate dot-product job.
// A job loads an initial addend, then folds LEN a*b products into it over a
// valid/ready operand stream. The final sum is latched into result, and done
// pulses for one cycle when the job completes.
module mac_8_seq_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [DATA_WIDTH-1:0] init,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] acc;
    logic [LEN_WIDTH-1:0]  cnt;
    logic [DATA_WIDTH-1:0] mac_sum;
    logic                  beat;

    // The low DATA_WIDTH bits of a*b + acc depend only on the low bits of
    // the full product, so evaluating in DATA_WIDTH context gives the same
    // truncated sum as forming the 2*DATA_WIDTH product first.
    assign mac_sum = a * b + acc;

    // Operands are accepted only while running and not being cancelled;
    // abort withdraws ready in the same cycle so the pair is not consumed.
    assign in_ready = (state == RUN) && !abort;
    assign beat     = in_valid && in_ready;

    // busy and done are pure decodes of the state register.
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Job sequencer: accepts a job, counts down operand beats, latches result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        acc <= init;
                        cnt <= len;
                        if (len == '0) begin
                            result <= init;
                            state  <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (beat) begin
                        acc <= mac_sum;
                        cnt <= cnt - LEN_WIDTH'(1);
                        if (cnt == LEN_WIDTH'(1)) begin
                            result <= mac_sum;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_8_seq_ctrl.sv
// tb_mac_8_seq_ctrl: directed scoreboard bench for mac_8_seq_ctrl.
// Stimulus pushes the hand-computed final sum of each job that should
// complete; a monitor pops and compares whenever done is seen.
module tb_mac_8_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] len;
    logic [7:0] init;
    logic       abort;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;

    int         total_count;
    int         bad_count;
    logic [7:0] exp_q[$];

    mac_8_seq_ctrl #(
        .DATA_WIDTH(8),
        .LEN_WIDTH (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .len     (len),
        .init    (init),
        .abort   (abort),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total_count++;
        if (actual !== expected) begin
            bad_count++;
            $display("[TB] FAIL %s: got=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [3:0] l,
                                 input logic [7:0] i, input logic ab,
                                 input logic v, input logic [7:0] aa,
                                 input logic [7:0] bb);
        start    = s;
        len      = l;
        init     = i;
        abort    = ab;
        in_valid = v;
        a        = aa;
        b        = bb;
    endtask

    task automatic next_cycle;
        @(negedge clk);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                total_count++;
                bad_count++;
                $display("[TB] FAIL unexpected_done: got result=%0d expected no done", result);
            end else begin
                checkOutput("sb_result", 32'(result), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        total_count = 0;
        bad_count   = 0;
        rst_n       = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        repeat (2) next_cycle();

        // Reset state
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_ready", 32'(in_ready), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_result", 32'(result), 0);

        // Test 1: reset asserted mid-job (cnt=2) returns to IDLE without done
        rst_n = 1'b1;
        applyStimulus(1, 2, 9, 0, 0, 0, 0);
        next_cycle();
        checkOutput("t1_busy_run", 32'(busy), 1);
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 1, 1, 1);
        repeat (2) next_cycle();
        #1;
        checkOutput("t1_busy", 32'(busy), 0);
        checkOutput("t1_ready", 32'(in_ready), 0);
        checkOutput("t1_result", 32'(result), 0);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        checkOutput("t1_idle_after", 32'(busy), 0);

        // Test 2: len=3 init=5, pairs (2,3),(4,5),(1,1) -> 32
        exp_q.push_back(8'd32);
        applyStimulus(1, 3, 5, 0, 0, 0, 0);
        next_cycle();
        applyStimulus(0, 0, 0, 0, 1, 2, 3);
        #1 checkOutput("t2_ready_c1", 32'(in_ready), 1);
        next_cycle();
        applyStimulus(0, 0, 0, 0, 1, 4, 5);
        next_cycle();
        applyStimulus(0, 0, 0, 0, 1, 1, 1);
        checkOutput("t2_no_done_c3", 32'(done), 0);
        next_cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_done_c4", 32'(done), 1);
        checkOutput("t2_busy_c4", 32'(busy), 1);
        checkOutput("t2_ready_c4", 32'(in_ready), 0);
        next_cycle();
        checkOutput("t2_busy_c5", 32'(busy), 0);
        checkOutput("t2_result_held", 32'(result), 32);

        // Test 3: len=2 init=0, pairs (200,2),(100,2) -> 344 mod 256 = 88
        exp_q.push_back(8'd88);
        applyStimulus(1, 2, 0, 0, 0, 0, 0);
        next_cycle();
        applyStimulus(0, 0, 0, 0, 1, 200, 2);
        next_cycle();
        applyStimulus(0, 0, 0, 0, 1, 100, 2);
        next_cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t3_done", 32'(done), 1);
        next_cycle();

        // Test 4: len=2 init=1, valid 0,1,0,0,1 with (3,3),(2,2) -> 14
        exp_q.push_back(8'd14);
        applyStimulus(1, 2, 1, 0, 0, 0, 0);
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            case (k)
                1:       applyStimulus(0, 0, 0, 0, 1, 3, 3);
                4:       applyStimulus(0, 0, 0, 0, 1, 2, 2);
                default: applyStimulus(0, 0, 0, 0, 0, 8'hEE, 8'hEE);
            endcase
            #1;
            checkOutput($sformatf("t4_ready_c%0d", k + 1), 32'(in_ready), 1);
            checkOutput($sformatf("t4_no_done_c%0d", k + 1), 32'(done), 0);
            next_cycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_done", 32'(done), 1);
        next_cycle();

        // Test 5: len=0 init=0x5A -> done next cycle, result=init
        exp_q.push_back(8'h5A);
        applyStimulus(1, 0, 8'h5A, 0, 0, 0, 0);
        #1 checkOutput("t5_ready_c0", 32'(in_ready), 0);
        next_cycle();
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        #1;
        checkOutput("t5_done_c1", 32'(done), 1);
        checkOutput("t5_ready_c1", 32'(in_ready), 0);
        next_cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t5_busy_c2", 32'(busy), 0);

        // Test 6a: len=2 init=1, pairs (2,3),(0,0) -> 7
        exp_q.push_back(8'd7);
        applyStimulus(1, 2, 1, 0, 0, 0, 0);
        next_cycle();
        applyStimulus(0, 0, 0, 0, 1, 2, 3);
        next_cycle();
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        next_cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_done_first", 32'(done), 1);
        next_cycle();

        // Test 6b: new job; start pulsed in RUN; abort with the last beat
        applyStimulus(1, 2, 0, 0, 0, 0, 0);
        next_cycle();
        applyStimulus(1, 1, 8'h33, 0, 1, 1, 1);
        next_cycle();
        applyStimulus(0, 0, 0, 1, 1, 5, 5);
        #1 checkOutput("t6_ready_abort", 32'(in_ready), 0);
        next_cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_busy_after_abort", 32'(busy), 0);
        checkOutput("t6_done_after_abort", 32'(done), 0);
        checkOutput("t6_result_kept", 32'(result), 7);
        next_cycle();
        checkOutput("t6_still_idle", 32'(busy), 0);

        // start together with abort in IDLE is refused
        applyStimulus(1, 1, 8'h44, 1, 0, 0, 0);
        next_cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_start_abort_idle", 32'(busy), 0);

        // Fresh job afterwards: len=1 init=2, (3,3) -> 11
        exp_q.push_back(8'd11);
        applyStimulus(1, 1, 2, 0, 0, 0, 0);
        next_cycle();
        applyStimulus(0, 0, 0, 0, 1, 3, 3);
        next_cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_final_done", 32'(done), 1);
        repeat (3) next_cycle();

        checkOutput("sb_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule
